mesm6_useq: RTL and testbench
=============================

# mesm6_useq

Parametrised microcode sequencer for the MESM-6 core family: computes the next microcode PC from the current micro-op sequencing fields, condition flags, opcode dispatch address and interrupt request. Generalises the core's inline sequencer with a configurable condition vector (select and invert), a microsubroutine call/return stack and a hardware loop counter. Sits between the microinstruction ROM and the datapath; `upc` addresses the ROM, whose registered output feeds this block's control inputs back.

## Interface
- `UPC_BITS`, 8, width of microcode address.
- `NCOND`, 8, number of condition inputs.
- `STACK_DEPTH`, 4, return-stack entries (≥1).
- `CNT_BITS`, 6, loop counter width (≤ `UPC_BITS`).
- `UADDR_RESET`, 0, reset vector.
- `UADDR_INTERRUPT`, 1, interrupt vector.
- `UADDR_ERROR`, 2, stack-fault vector.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `busy`  in  1  stall; no state changes while high.
- `seq_op`  in  3  sequencing operation (encoding in package).
- `cond_sel`  in  clog2(`NCOND`)  condition index.
- `cond_inv`  in  1  invert selected condition.
- `uaddr`  in  `UPC_BITS`  target address / counter load value.
- `cond`  in  `NCOND`  condition flags (e.g. A==0, A<0, op not cached).
- `dispatch_addr`  in  `UPC_BITS`  routine entry for the decoded opcode.
- `int_requested`  in  1  pending interrupt.
- `upc`  out  `UPC_BITS`  microcode PC.
- `cnt_zero`  out  1  loop counter == 0.
- `stack_depth`  out  clog2(`STACK_DEPTH`+1)  current number of stacked entries.
- `stack_fault`  out  1  sticky overflow/underflow flag.

## Operation
- Reset: `upc`=`UADDR_RESET`, counter=0 (`cnt_zero`=1), depth=0, `stack_fault`=0.
- Each rising edge with `busy`=0 executes `seq_op`; with `busy`=1 all registers hold.
- `NEXT`: upc+1, wraps modulo 2^`UPC_BITS`.
- `JUMP`: upc = `uaddr`.
- `CJUMP`: t = `cond[cond_sel]` ^ `cond_inv`; upc = t ? `uaddr` : upc+1. `cond_sel` ≥ `NCOND` reads as 0.
- `CALL`: push upc+1, upc = `uaddr`.
- `RET`: pop; upc = popped value.
- `DECODE`: upc = `int_requested` ? `UADDR_INTERRUPT` : `dispatch_addr`.
- `LDCNT`: counter = `uaddr[CNT_BITS-1:0]`, upc+1.
- `LOOP`: counter≠0 → counter−1, upc = `uaddr`; counter=0 → upc+1, counter stays 0.
- Overflow (`CALL` at depth=`STACK_DEPTH`) or underflow (`RET` at depth 0): no push/pop, depth unchanged, upc = `UADDR_ERROR`, `stack_fault` set. Cleared only by reset.
- Stack is LIFO; depth saturates at the bounds described above; entries above depth are don't-care.

## Timing
- Single-cycle: next `upc` is registered on the edge that consumes the current control fields; ROM adds one cycle, so consecutive micro-ops issue every cycle when not busy.
- `cond`, `dispatch_addr` and `int_requested` are sampled on the same edge; no internal pipelining.
- `cnt_zero`, `stack_depth` and `stack_fault` are registered-state decodes valid the cycle after the update.
- Reset asserted mid-stall or mid-loop forces reset values immediately (asynchronously); the first operation executes on the first edge after deassertion.
- Reserved `seq_op` encodings behave as `NEXT`.

## Structure
- Package `mesm6_useq_pkg`: `seq_op_t` enum (NEXT=0, JUMP, CJUMP, CALL, RET, DECODE, LDCNT, LOOP) and default vector constants. The core's `mesm6_defines.sv` maps the uop bit fields onto these ports.
- One sub-module, `mesm6_ustack`: parametrised LIFO (push/pop/depth/full/empty). Next-upc mux and loop counter stay in the top level.

## Test plan
- Reset, then 3× `NEXT` → upc 0,1,2,3; with `busy` high for 2 cycles, upc holds at 3.
- `CJUMP` with `cond_sel`=2, `uaddr`=0x40: cond[2]=1, inv=0 → 0x40; cond[2]=1, inv=1 → upc+1.
- `CALL` 0x10 from upc 5, nested `CALL` 0x20 from 0x10, then 2× `RET` → 0x20, then 0x11, then 6; depth 0→1→2→1→0.
- With `STACK_DEPTH`=4: 5 consecutive `CALL`s → 5th sets upc=`UADDR_ERROR`, `stack_fault`=1, depth stays 4; `RET` at depth 0 → same fault behaviour.
- `LDCNT` 3 then `LOOP` to self → loop body executes 4 times total, falls through with `cnt_zero`=1.
- `DECODE` with `dispatch_addr`=0x33: `int_requested`=0 → 0x33; `int_requested`=1 → `UADDR_INTERRUPT`. Reset pulse mid-loop → upc=`UADDR_RESET`, counter 0, depth 0.

Source files
------------

// File: rtl/mesm6_useq_pkg.sv
// Shared encodings and default vectors for the MESM-6 microcode sequencer.
package mesm6_useq_pkg;

    localparam int unsigned SEQ_OP_BITS = 3;

    typedef enum logic [SEQ_OP_BITS-1:0] {
        SEQ_NEXT   = 3'd0,
        SEQ_JUMP   = 3'd1,
        SEQ_CJUMP  = 3'd2,
        SEQ_CALL   = 3'd3,
        SEQ_RET    = 3'd4,
        SEQ_DECODE = 3'd5,
        SEQ_LDCNT  = 3'd6,
        SEQ_LOOP   = 3'd7
    } seq_op_t;

    localparam int unsigned DEF_UPC_BITS        = 8;
    localparam int unsigned DEF_NCOND           = 8;
    localparam int unsigned DEF_STACK_DEPTH     = 4;
    localparam int unsigned DEF_CNT_BITS        = 6;
    localparam int unsigned DEF_UADDR_RESET     = 0;
    localparam int unsigned DEF_UADDR_INTERRUPT = 1;
    localparam int unsigned DEF_UADDR_ERROR     = 2;

    // Index width that stays legal when only one item exists.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mesm6_ustack.sv
// Parametrised LIFO holding microsubroutine return addresses.
module mesm6_ustack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_top_c,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_full_c,
    output logic                       o_empty_c
);
    localparam int unsigned DB = $clog2(DEPTH + 1);
    localparam int unsigned IB = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DB-1:0]    r_depth;
    logic [IB-1:0]    w_wr_idx;
    logic [IB-1:0]    w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_depth == DB'(DEPTH));
    assign o_empty_c = (r_depth == '0);
    assign w_do_push = i_push && !o_full_c;
    assign w_do_pop  = i_pop && !o_empty_c;
    assign w_wr_idx  = IB'(r_depth);
    assign w_rd_idx  = IB'(r_depth - DB'(1));
    assign o_top_c   = r_mem[w_rd_idx];
    assign o_depth   = r_depth;

    // Entries above the current depth are don't-care, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth <= '0;
        end else if (w_do_push) begin
            r_depth <= r_depth + DB'(1);
        end else if (w_do_pop) begin
            r_depth <= r_depth - DB'(1);
        end
    end

endmodule

// File: rtl/mesm6_useq.sv
// MESM-6 microcode sequencer: next-upc selection, loop counter and return stack.
module mesm6_useq
    import mesm6_useq_pkg::*;
#(
    parameter int unsigned UPC_BITS        = DEF_UPC_BITS,
    parameter int unsigned NCOND           = DEF_NCOND,
    parameter int unsigned STACK_DEPTH     = DEF_STACK_DEPTH,
    parameter int unsigned CNT_BITS        = DEF_CNT_BITS,
    parameter int unsigned UADDR_RESET     = DEF_UADDR_RESET,
    parameter int unsigned UADDR_INTERRUPT = DEF_UADDR_INTERRUPT,
    parameter int unsigned UADDR_ERROR     = DEF_UADDR_ERROR
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             busy,
    input  logic [SEQ_OP_BITS-1:0]           seq_op,
    input  logic [idx_bits(NCOND)-1:0]       cond_sel,
    input  logic                             cond_inv,
    input  logic [UPC_BITS-1:0]              uaddr,
    input  logic [NCOND-1:0]                 cond,
    input  logic [UPC_BITS-1:0]              dispatch_addr,
    input  logic                             int_requested,
    output logic [UPC_BITS-1:0]              upc,
    output logic                             cnt_zero,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             stack_fault
);
    logic [UPC_BITS-1:0] r_upc;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_cnt_zero;
    logic                r_fault;

    logic [UPC_BITS-1:0] w_upc_inc;
    logic [UPC_BITS-1:0] w_upc_next;
    logic [CNT_BITS-1:0] w_cnt_next;
    logic [UPC_BITS-1:0] w_stk_top;
    logic                w_stk_full;
    logic                w_stk_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_fault_set;
    logic                w_cond_bit;

    assign w_upc_inc  = r_upc + UPC_BITS'(1);
    assign w_cond_bit = (32'(cond_sel) < NCOND) ? cond[cond_sel] : 1'b0;

    mesm6_ustack #(
        .WIDTH (UPC_BITS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push && !busy),
        .i_pop     (w_pop && !busy),
        .i_data    (w_upc_inc),
        .o_top_c   (w_stk_top),
        .o_depth   (stack_depth),
        .o_full_c  (w_stk_full),
        .o_empty_c (w_stk_empty)
    );

    // Next-upc mux; stack faults divert to the error vector instead of moving the stack.
    always_comb begin
        w_upc_next  = w_upc_inc;
        w_cnt_next  = r_cnt;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_fault_set = 1'b0;
        case (seq_op_t'(seq_op))
            SEQ_JUMP:   w_upc_next = uaddr;
            SEQ_CJUMP:  if (w_cond_bit ^ cond_inv) w_upc_next = uaddr;
            SEQ_CALL: begin
                if (w_stk_full) begin
                    w_upc_next  = UPC_BITS'(UADDR_ERROR);
                    w_fault_set = 1'b1;
                end else begin
                    w_push     = 1'b1;
                    w_upc_next = uaddr;
                end
            end
            SEQ_RET: begin
                if (w_stk_empty) begin
                    w_upc_next  = UPC_BITS'(UADDR_ERROR);
                    w_fault_set = 1'b1;
                end else begin
                    w_pop      = 1'b1;
                    w_upc_next = w_stk_top;
                end
            end
            SEQ_DECODE: w_upc_next = int_requested ? UPC_BITS'(UADDR_INTERRUPT) : dispatch_addr;
            SEQ_LDCNT:  w_cnt_next = uaddr[CNT_BITS-1:0];
            SEQ_LOOP: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_BITS'(1);
                    w_upc_next = uaddr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upc      <= UPC_BITS'(UADDR_RESET);
            r_cnt      <= '0;
            r_cnt_zero <= 1'b1;
            r_fault    <= 1'b0;
        end else if (!busy) begin
            r_upc      <= w_upc_next;
            r_cnt      <= w_cnt_next;
            r_cnt_zero <= (w_cnt_next == '0);
            if (w_fault_set) r_fault <= 1'b1;
        end
    end

    assign upc         = r_upc;
    assign cnt_zero    = r_cnt_zero;
    assign stack_fault = r_fault;

endmodule

// File: tb/tb_mesm6_useq.sv
// Directed bench for mesm6_useq with a queue-based reference model checked every cycle.
module tb_mesm6_useq;
    import mesm6_useq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy = 1'b0;
    logic [2:0] seq_op = 3'd0;
    logic [2:0] cond_sel = 3'd0;
    logic       cond_inv = 1'b0;
    logic [7:0] uaddr = 8'd0;
    logic [7:0] cond = 8'd0;
    logic [7:0] dispatch_addr = 8'd0;
    logic       int_requested = 1'b0;
    logic [7:0] upc;
    logic       cnt_zero;
    logic [2:0] stack_depth;
    logic       stack_fault;

    int n_vec = 0;
    int n_err = 0;

    // Reference state
    int m_upc = 0;
    int m_cnt = 0;
    int m_fault = 0;
    int m_stk[$];

    mesm6_useq dut (
        .clk           (clk),
        .reset         (reset),
        .busy          (busy),
        .seq_op        (seq_op),
        .cond_sel      (cond_sel),
        .cond_inv      (cond_inv),
        .uaddr         (uaddr),
        .cond          (cond),
        .dispatch_addr (dispatch_addr),
        .int_requested (int_requested),
        .upc           (upc),
        .cnt_zero      (cnt_zero),
        .stack_depth   (stack_depth),
        .stack_fault   (stack_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural rules on plain integers and a queue.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_upc = 0;
            m_cnt = 0;
            m_fault = 0;
            m_stk.delete();
        end else if (!busy) begin
            int nxt;
            int t;
            nxt = (m_upc + 1) % 256;
            case (seq_op)
                3'd1: m_upc = uaddr;
                3'd2: begin
                    t = (cond_sel < 8) ? int'(cond[cond_sel]) : 0;
                    m_upc = ((t ^ int'(cond_inv)) != 0) ? int'(uaddr) : nxt;
                end
                3'd3: begin
                    if (m_stk.size() == 4) begin
                        m_upc = 2;
                        m_fault = 1;
                    end else begin
                        m_stk.push_back(nxt);
                        m_upc = uaddr;
                    end
                end
                3'd4: begin
                    if (m_stk.size() == 0) begin
                        m_upc = 2;
                        m_fault = 1;
                    end else begin
                        m_upc = m_stk.pop_back();
                    end
                end
                3'd5: m_upc = int_requested ? 1 : int'(dispatch_addr);
                3'd6: begin
                    m_cnt = uaddr % 64;
                    m_upc = nxt;
                end
                3'd7: begin
                    if (m_cnt != 0) begin
                        m_cnt = m_cnt - 1;
                        m_upc = uaddr;
                    end else begin
                        m_upc = nxt;
                    end
                end
                default: m_upc = nxt;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_upc", int'(upc), m_upc);
        chk("cyc_cnt_zero", int'(cnt_zero), (m_cnt == 0) ? 1 : 0);
        chk("cyc_depth", int'(stack_depth), m_stk.size());
        chk("cyc_fault", int'(stack_fault), m_fault);
    end

    task automatic op(input logic [2:0] o, input logic [7:0] a,
                      input logic [2:0] s = 3'd0, input logic inv = 1'b0);
        seq_op   = o;
        uaddr    = a;
        cond_sel = s;
        cond_inv = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic stall(input int n);
        busy   = 1'b1;
        seq_op = SEQ_JUMP;
        uaddr  = 8'h77;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("stall_upc", int'(upc), 3);
        end
        busy = 1'b0;
    endtask

    task automatic do_reset();
        seq_op = SEQ_NEXT;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        chk("rst_upc", int'(upc), 0);
        chk("rst_cnt_zero", int'(cnt_zero), 1);
        chk("rst_depth", int'(stack_depth), 0);
        chk("rst_fault", int'(stack_fault), 0);
    endtask

    initial begin
        int body;
        do_reset();

        // Sequential fetch and stall
        op(SEQ_NEXT, 8'h00); chk("next1", int'(upc), 1);
        op(SEQ_NEXT, 8'h00); chk("next2", int'(upc), 2);
        op(SEQ_NEXT, 8'h00); chk("next3", int'(upc), 3);
        stall(2);

        // Conditional jumps
        cond = 8'h04;
        op(SEQ_CJUMP, 8'h40, 3'd2, 1'b0); chk("cj_taken", int'(upc), 8'h40);
        op(SEQ_CJUMP, 8'h40, 3'd2, 1'b1); chk("cj_inv_fall", int'(upc), 8'h41);
        cond = 8'h00;
        op(SEQ_CJUMP, 8'h40, 3'd2, 1'b1); chk("cj_inv_taken", int'(upc), 8'h40);
        cond = 8'hDF;
        op(SEQ_CJUMP, 8'h10, 3'd5, 1'b0); chk("cj_sel5_fall", int'(upc), 8'h41);

        // Wrap at the top of the address space
        op(SEQ_JUMP, 8'hFF); chk("jump_ff", int'(upc), 8'hFF);
        op(SEQ_NEXT, 8'h00); chk("wrap", int'(upc), 0);

        // Nested calls and returns
        op(SEQ_JUMP, 8'h05);
        op(SEQ_CALL, 8'h10); chk("call1", int'(upc), 8'h10); chk("call1_d", int'(stack_depth), 1);
        op(SEQ_CALL, 8'h20); chk("call2", int'(upc), 8'h20); chk("call2_d", int'(stack_depth), 2);
        op(SEQ_RET, 8'h00);  chk("ret1", int'(upc), 8'h11); chk("ret1_d", int'(stack_depth), 1);
        op(SEQ_RET, 8'h00);  chk("ret2", int'(upc), 6);     chk("ret2_d", int'(stack_depth), 0);
        op(SEQ_RET, 8'h00);  chk("under_upc", int'(upc), 2); chk("under_fault", int'(stack_fault), 1);
        chk("under_d", int'(stack_depth), 0);

        // Overflow at full depth
        do_reset();
        op(SEQ_CALL, 8'h10);
        op(SEQ_CALL, 8'h20);
        op(SEQ_CALL, 8'h30);
        op(SEQ_CALL, 8'h40); chk("full_d", int'(stack_depth), 4); chk("full_fault", int'(stack_fault), 0);
        op(SEQ_CALL, 8'h50); chk("over_upc", int'(upc), 2); chk("over_fault", int'(stack_fault), 1);
        chk("over_d", int'(stack_depth), 4);
        op(SEQ_RET, 8'h00); chk("pop4", int'(upc), 8'h31);
        op(SEQ_RET, 8'h00); chk("pop3", int'(upc), 8'h21);
        op(SEQ_RET, 8'h00); chk("pop2", int'(upc), 8'h11);
        op(SEQ_RET, 8'h00); chk("pop1", int'(upc), 8'h01);
        op(SEQ_RET, 8'h00); chk("under2_upc", int'(upc), 2); chk("under2_d", int'(stack_depth), 0);

        // Hardware loop: body at upc 1, LOOP at upc 2 back to 1
        do_reset();
        op(SEQ_LDCNT, 8'h03); chk("ldcnt_upc", int'(upc), 1); chk("ldcnt_nz", int'(cnt_zero), 0);
        body = 0;
        for (int i = 0; i < 10; i++) begin
            op(SEQ_NEXT, 8'h00);
            body++;
            op(SEQ_LOOP, 8'h01);
            if (upc != 8'h01) break;
        end
        chk("loop_body", body, 4);
        chk("loop_exit", int'(upc), 3);
        chk("loop_cz", int'(cnt_zero), 1);

        // Opcode dispatch and interrupt
        dispatch_addr = 8'h33;
        int_requested = 1'b0;
        op(SEQ_DECODE, 8'h00); chk("dec_dispatch", int'(upc), 8'h33);
        int_requested = 1'b1;
        op(SEQ_DECODE, 8'h00); chk("dec_int", int'(upc), 1);
        int_requested = 1'b0;

        // Asynchronous reset during a stalled loop with a live stack entry
        op(SEQ_LDCNT, 8'h05);
        op(SEQ_CALL, 8'h50);
        op(SEQ_LOOP, 8'h50); chk("mid_upc", int'(upc), 8'h50); chk("mid_d", int'(stack_depth), 1);
        busy = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_upc", int'(upc), 0);
        chk("async_cz", int'(cnt_zero), 1);
        chk("async_d", int'(stack_depth), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        busy  = 1'b0;
        op(SEQ_NEXT, 8'h00); chk("post_rst", int'(upc), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
